periodogram_avg: RTL and testbench

Parametrised successor to the single-frame squared periodogram. Computes per-bin power (re^2 + im^2) >>> Q for complex FFT output frames of NF bins. Averages 2^NAVG_LOG2 consecutive frames (Welch-style) in an internal accumulator memory, then drains one averaged frame with valid/ready handshaking. Sits between the FFT and the mel filterbank in the feature pipeline.

---
 rtl/periodogram_pkg.sv | 21 ++
 rtl/periodogram_acc_ram.sv | 26 ++
 rtl/periodogram_avg.sv | 207 ++++++++++++++++++++
 tb/tb_periodogram_avg.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/periodogram_pkg.sv
// Shared types and helpers for the averaged periodogram block.
package periodogram_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2
  } state_e;

  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned navg_log2);
    return 2 * dw + 1 + navg_log2;
  endfunction

  // Clamp an unsigned value to the largest ow-bit number.
  function automatic logic [127:0] sat_trunc(input logic [127:0] v, input int unsigned ow);
    logic [127:0] lim;
    lim = (ow >= 128) ? '1 : ((128'd1 << ow) - 128'd1);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/periodogram_acc_ram.sv
// Accumulator memory: one synchronous read port (1-cycle latency, output held
// when not reading) and one write port.
module periodogram_acc_ram
  import periodogram_pkg::*;
#(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned AW    = 9,
  parameter int unsigned W     = 35
) (
  input  logic          clk,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/periodogram_avg.sv
// Welch-style averaged squared periodogram: accumulates 2^NAVG_LOG2 frames of
// bin power, then drains one averaged frame. Peak tracking: PERIODOGRAM_PEAK_EN.
module periodogram_avg
  import periodogram_pkg::*;
#(
  parameter int unsigned DW        = 16,
  parameter int unsigned NF        = 512,
  parameter int unsigned Q         = 15,
  parameter int unsigned NAVG_LOG2 = 2,
  parameter int unsigned OW        = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DW-1:0]         sample_in_real,
  input  logic [DW-1:0]         sample_in_imag,
  input  logic                  sample_valid,
  input  logic                  sample_last,
  output logic                  sample_ready,
  output logic [OW-1:0]         periodogram_out,
  output logic [$clog2(NF)-1:0] periodogram_bin,
  output logic                  periodogram_valid,
  output logic                  periodogram_last,
  input  logic                  periodogram_ready,
  output logic                  frame_err,
  output logic [$clog2(NF)-1:0] peak_bin,
  output logic [OW-1:0]         peak_value
);

  localparam int unsigned   AW         = $clog2(NF);
  localparam int unsigned   ACW        = acc_width(DW, NAVG_LOG2);
  localparam int unsigned   FW         = (NAVG_LOG2 > 0) ? NAVG_LOG2 : 1;
  localparam logic [AW-1:0] BIN_LAST   = AW'(NF - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'((1 << NAVG_LOG2) - 1);

  state_e                 state_q;
  logic                   flush_q, sample_ready_q, frame_err_q;
  logic [AW-1:0]          bin_q;
  logic [FW-1:0]          frame_q;
  logic                   s1_valid_q, s1_first_q;
  logic [AW-1:0]          s1_bin_q;
  logic signed [2*DW-1:0] s1_rr_q, s1_ii_q;
  logic [AW-1:0]          ptr_q, pend_bin_q, out_bin_q;
  logic                   issued_all_q, rd_pend_q;
  logic                   out_valid_q, out_last_q;
  logic [OW-1:0]          out_q;

  logic                   accept, at_last_bin, good_end, bad_beat, hs, load, issue;
  logic signed [2*DW-1:0] re_x, im_x;
  logic signed [2*DW:0]   sum;
  logic [ACW-1:0]         power, rd_data, wr_data;
  logic [AW-1:0]          rd_addr;
  logic [OW-1:0]          drain_val;

  assign accept      = sample_valid & sample_ready_q;
  assign at_last_bin = (bin_q == BIN_LAST);
  assign good_end    = accept & sample_last & at_last_bin;
  assign bad_beat    = accept & (sample_last ^ at_last_bin);
  assign re_x        = (2*DW)'($signed(sample_in_real));
  assign im_x        = (2*DW)'($signed(sample_in_imag));

  assign sum     = {s1_rr_q[2*DW-1], s1_rr_q} + {s1_ii_q[2*DW-1], s1_ii_q};
  assign power   = ACW'(sum >>> Q);
  assign wr_data = s1_first_q ? power : rd_data + power;

  // Drain keeps one read in flight ahead of the output register so that a
  // continuously-ready sink sees one beat per cycle.
  assign hs        = out_valid_q & periodogram_ready;
  assign load      = rd_pend_q & (~out_valid_q | periodogram_ready);
  assign issue     = (state_q == DRAIN) & ~issued_all_q & (~rd_pend_q | load);
  assign rd_addr   = (state_q == DRAIN) ? ptr_q : bin_q;
  assign drain_val = OW'(sat_trunc(128'(rd_data >> NAVG_LOG2), OW));

  periodogram_acc_ram #(.DEPTH(NF), .AW(AW), .W(ACW)) u_ram (
    .clk     (clk),
    .rd_en   (accept | issue),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_en   (s1_valid_q),
    .wr_addr (s1_bin_q),
    .wr_data (wr_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ACCUM;
      flush_q        <= 1'b0;
      sample_ready_q <= 1'b1;
      frame_err_q    <= 1'b0;
      bin_q          <= '0;
      frame_q        <= '0;
      s1_valid_q     <= 1'b0;
      s1_first_q     <= 1'b0;
      s1_bin_q       <= '0;
      s1_rr_q        <= '0;
      s1_ii_q        <= '0;
      ptr_q          <= '0;
      pend_bin_q     <= '0;
      issued_all_q   <= 1'b0;
      rd_pend_q      <= 1'b0;
      out_valid_q    <= 1'b0;
      out_last_q     <= 1'b0;
      out_q          <= '0;
      out_bin_q      <= '0;
    end else begin
      frame_err_q <= bad_beat;
      s1_valid_q  <= accept;
      if (accept) begin
        s1_first_q <= (frame_q == '0);
        s1_bin_q   <= bin_q;
        s1_rr_q    <= re_x * re_x;
        s1_ii_q    <= im_x * im_x;
      end
      case (state_q)
        ACCUM: begin
          if (bad_beat) begin
            bin_q   <= '0;
            frame_q <= '0;
          end else if (good_end) begin
            bin_q <= '0;
            if (frame_q == FRAME_LAST) begin
              frame_q        <= '0;
              state_q        <= FLUSH;
              flush_q        <= 1'b0;
              sample_ready_q <= 1'b0;
            end else begin
              frame_q <= frame_q + 1'b1;
            end
          end else if (accept) begin
            bin_q <= bin_q + 1'b1;
          end
        end
        FLUSH: begin
          flush_q <= 1'b1;
          if (flush_q) begin
            state_q      <= DRAIN;
            ptr_q        <= '0;
            issued_all_q <= 1'b0;
            rd_pend_q    <= 1'b0;
          end
        end
        DRAIN: begin
          if (issue) begin
            ptr_q      <= ptr_q + 1'b1;
            pend_bin_q <= ptr_q;
            if (ptr_q == BIN_LAST) issued_all_q <= 1'b1;
          end
          rd_pend_q <= issue | (rd_pend_q & ~load);
          if (load) begin
            out_valid_q <= 1'b1;
            out_q       <= drain_val;
            out_bin_q   <= pend_bin_q;
            out_last_q  <= (pend_bin_q == BIN_LAST);
          end else if (hs) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
          end
          if (hs && out_last_q) begin
            state_q        <= ACCUM;
            sample_ready_q <= 1'b1;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign sample_ready      = sample_ready_q;
  assign frame_err         = frame_err_q;
  assign periodogram_valid = out_valid_q;
  assign periodogram_last  = out_last_q;
  assign periodogram_out   = out_q;
  assign periodogram_bin   = out_bin_q;

`ifdef PERIODOGRAM_PEAK_EN
  logic [OW-1:0] run_max_q, peak_value_q;
  logic [AW-1:0] run_bin_q, peak_bin_q;
  logic          take;

  // Strict compare keeps the lower bin on ties; bin 0 restarts the search.
  assign take = (out_bin_q == '0) || (out_q > run_max_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_max_q    <= '0;
      run_bin_q    <= '0;
      peak_value_q <= '0;
      peak_bin_q   <= '0;
    end else if (hs) begin
      if (take) begin
        run_max_q <= out_q;
        run_bin_q <= out_bin_q;
      end
      if (out_last_q) begin
        peak_value_q <= take ? out_q : run_max_q;
        peak_bin_q   <= take ? out_bin_q : run_bin_q;
      end
    end
  end

  assign peak_bin   = peak_bin_q;
  assign peak_value = peak_value_q;
`else
  assign peak_bin   = '0;
  assign peak_value = '0;
`endif

endmodule

// File: tb/tb_periodogram_avg.sv
// Scoreboarded bench for periodogram_avg: an OW=32 and an OW=16 instance share
// one input stream and one ready, each with its own expected-beat queue.
module tb_periodogram_avg;

  typedef struct {
    longint val;
    int     bin;
    bit     last;
  } beat_t;

  typedef struct {
    int     re_c, re_k, re_f, im_c, im_k;
    longint exp[8];
    int     pk_bin;
    longint pk_val;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] re_i = '0, im_i = '0;
  logic        s_valid = 1'b0, s_last = 1'b0, p_ready = 1'b1;

  logic        sr_a, pv_a, pl_a, fe_a, sr_b, pv_b, pl_b, fe_b;
  logic [31:0] po_a, pkv_a;
  logic [15:0] po_b, pkv_b;
  logic [2:0]  pb_a, pkb_a, pb_b, pkb_b;

  int    pass_cnt = 0, total_cnt = 0, err_pulses = 0;
  beat_t qa[$], qb[$];
  vec_t  vt[4];

  always #5 clk = ~clk;

  periodogram_avg #(.DW(16), .NF(8), .Q(15), .NAVG_LOG2(2), .OW(32)) dut_a (
    .clk(clk), .rst(rst), .sample_in_real(re_i), .sample_in_imag(im_i),
    .sample_valid(s_valid), .sample_last(s_last), .sample_ready(sr_a),
    .periodogram_out(po_a), .periodogram_bin(pb_a), .periodogram_valid(pv_a),
    .periodogram_last(pl_a), .periodogram_ready(p_ready), .frame_err(fe_a),
    .peak_bin(pkb_a), .peak_value(pkv_a)
  );

  periodogram_avg #(.DW(16), .NF(8), .Q(15), .NAVG_LOG2(2), .OW(16)) dut_b (
    .clk(clk), .rst(rst), .sample_in_real(re_i), .sample_in_imag(im_i),
    .sample_valid(s_valid), .sample_last(s_last), .sample_ready(sr_b),
    .periodogram_out(po_b), .periodogram_bin(pb_b), .periodogram_valid(pv_b),
    .periodogram_last(pl_b), .periodogram_ready(p_ready), .frame_err(fe_b),
    .peak_bin(pkb_b), .peak_value(pkv_b)
  );

  task automatic check(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic longint sat16(input longint v);
    return (v > 65535) ? 65535 : v;
  endfunction

  always @(negedge clk) begin
    beat_t e;
    if (fe_a) err_pulses++;
    if (pv_a && p_ready) begin
      if (qa.size() == 0) check("unexpected_beat_a", 1, 0);
      else begin
        e = qa.pop_front();
        check($sformatf("val_a_bin%0d", e.bin), po_a, e.val);
        check($sformatf("binlast_a_bin%0d", e.bin), {pb_a, pl_a}, e.bin * 2 + int'(e.last));
      end
    end
    if (pv_b && p_ready) begin
      if (qb.size() == 0) check("unexpected_beat_b", 1, 0);
      else begin
        e = qb.pop_front();
        check($sformatf("val_b_bin%0d", e.bin), po_b, e.val);
        check($sformatf("binlast_b_bin%0d", e.bin), {pb_b, pl_b}, e.bin * 2 + int'(e.last));
      end
    end
  end

  task automatic send_beat(input int re, input int im, input bit lst);
    int g = 0;
    re_i = 16'(re); im_i = 16'(im); s_last = lst; s_valid = 1'b1;
    while (!sr_a && g < 500) begin @(posedge clk); #1; g++; end
    if (!sr_a) check("sample_ready_timeout", 0, 1);
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic push_exp(input int v, input int i);
    beat_t b;
    b.val = vt[v].exp[i]; b.bin = i; b.last = (i == 7);
    qa.push_back(b);
    b.val = sat16(vt[v].exp[i]);
    qb.push_back(b);
  endtask

  task automatic send_frame(input int v, input int f, input int n, input int last_at, input int push_upto);
    for (int i = 0; i < n; i++) begin
      if (i < push_upto) push_exp(v, i);
      send_beat(vt[v].re_c + vt[v].re_k * i + vt[v].re_f * f,
                vt[v].im_c + vt[v].im_k * i, i == last_at);
    end
  endtask

  task automatic run_avg(input int v, input int push_upto);
    for (int f = 0; f < 4; f++) send_frame(v, f, 8, 7, (f == 3) ? push_upto : 0);
  endtask

  task automatic wait_drain();
    int g = 0;
    while ((qa.size() != 0 || qb.size() != 0) && g < 300) begin @(posedge clk); #1; g++; end
    if (qa.size() != 0 || qb.size() != 0) check("drain_timeout", 0, 1);
    check("sample_ready_after_drain", {sr_a, sr_b}, 2'b11);
  endtask

  task automatic check_peak(input int v);
    longint eb, ev;
`ifdef PERIODOGRAM_PEAK_EN
    eb = vt[v].pk_bin; ev = vt[v].pk_val;
`else
    eb = 0; ev = 0;
`endif
    check("peak_bin_a", pkb_a, eb);
    check("peak_val_a", pkv_a, ev);
    check("peak_bin_b", pkb_b, eb);
    check("peak_val_b", pkv_b, sat16(ev));
  endtask

  task automatic wait_valid_bin(input int b, output bit found);
    int g = 0;
    while (!(pv_a && pb_a == 3'(b)) && g < 300) begin @(posedge clk); #1; g++; end
    found = pv_a && (pb_a == 3'(b));
    if (!found) check($sformatf("wait_bin%0d_timeout", b), 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", pass_cnt, total_cnt);
    $fatal(1);
  end

  initial begin
    bit          found;
    logic [31:0] hv;
    logic [3:0]  hbl;

    vt[0] = '{re_c: 0, re_k: 256, re_f: 0, im_c: 0, im_k: -256,
              exp: '{0, 4, 16, 36, 64, 100, 144, 196}, pk_bin: 7, pk_val: 196};
    vt[1] = '{re_c: 0, re_k: 0, re_f: 256, im_c: 0, im_k: 0,
              exp: '{7, 7, 7, 7, 7, 7, 7, 7}, pk_bin: 0, pk_val: 7};
    vt[2] = '{re_c: -32768, re_k: 0, re_f: 0, im_c: -32768, im_k: 0,
              exp: '{65536, 65536, 65536, 65536, 65536, 65536, 65536, 65536}, pk_bin: 0, pk_val: 65536};
    vt[3] = '{re_c: 1000, re_k: 0, re_f: 0, im_c: 1000, im_k: 0,
              exp: '{61, 61, 61, 61, 61, 61, 61, 61}, pk_bin: 0, pk_val: 61};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_sample_ready", {sr_a, sr_b}, 2'b11);
    check("rst_valid", {pv_a, pv_b}, 0);
    check("rst_last", {pl_a, pl_b}, 0);
    check("rst_out_a", po_a, 0);
    check("rst_out_b", po_b, 0);
    check("rst_bin", {pb_a, pb_b}, 0);
    check("rst_frame_err", {fe_a, fe_b}, 0);
    check("rst_peak", {pkb_a, pkv_a, pkb_b, pkv_b}, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Table-driven averages
    for (int v = 0; v < 4; v++) begin
      run_avg(v, 8);
      wait_drain();
      check_peak(v);
    end

    // Framing error: sample_last on bin 3 of frame 1
    send_frame(0, 0, 8, 7, 0);
    send_frame(0, 1, 4, 3, 0);
    check("frame_err_pulse", {fe_a, fe_b}, 2'b11);
    @(posedge clk); #1;
    check("frame_err_clear", {fe_a, fe_b}, 0);
    check("no_output_after_err", {pv_a, pv_b, sr_a}, 3'b001);
    run_avg(1, 8);
    wait_drain();
    check("frame_err_count", err_pulses, 1);
    check_peak(1);

    // Back-pressure at bin 2
    run_avg(0, 8);
    wait_valid_bin(2, found);
    if (found) begin
      p_ready = 1'b0;
      hv = po_a; hbl = {pb_a, pl_a};
      check("stall_val", hv, 16);
      for (int c = 0; c < 3; c++) begin
        @(posedge clk); #1;
        check("hold_val", po_a, hv);
        check("hold_bin_last", {pb_a, pl_a}, hbl);
        check("hold_valid", {pv_a, pv_b}, 2'b11);
        check("ready_low_in_drain", {sr_a, sr_b}, 0);
      end
      p_ready = 1'b1;
    end
    wait_drain();
    check_peak(0);

    // Reset during drain at bin 4
    run_avg(0, 4);
    wait_valid_bin(4, found);
    rst = 1'b0;
    #1;
    check("midrst_valid", {pv_a, pv_b}, 0);
    check("midrst_sample_ready", {sr_a, sr_b}, 2'b11);
    check("midrst_beats_left", qa.size() + qb.size(), 0);
    check("midrst_peak", {pkb_a, pkv_a}, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    run_avg(3, 8);
    wait_drain();
    check_peak(3);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
